ppu_vram_arb: RTL and testbench

PPU_VRAM_ARB -- requirements
Module: ppu_vram_arb

---
 rtl/ppu_vram_arb.sv | 164 ++++++++++++++++
 tb/tb_ppu_vram_arb.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_vram_arb.sv
// ppu_vram_arb
// Arbitrates CPU PPUADDR/PPUDATA accesses against the renderer for the
// nametable RAM, the pattern ROM and the palette RAM. The renderer has
// priority. A CPU access waits in REQ until the renderer frees VRAM for a
// cycle (the grant cycle).
//
// Ports
//   i_clk, i_rstn                 clock, asynchronous active-low reset
//   i_addr_wr                     $2006 write strobe (two writes form the address)
//   i_data_wr, i_data_rd          $2007 write / read strobes
//   i_wdata                       CPU write data
//   i_latch_clr                   PPUSTATUS read, clears the address toggle
//   i_inc32                       address step: 32 when set, else 1
//   i_rde_busy                    renderer owns VRAM this cycle
//   i_rde_nt/pt/plt_addr          renderer addresses, passed through when not granted
//   o_nt_addr/we/wdata, i_nt_rdata    nametable RAM port
//   o_pt_addr, i_pt_rdata             pattern ROM port ({plane1, plane0})
//   o_plt_addr/we/wdata, i_plt_rdata  palette RAM port
//   o_rdata                       CPU read value, valid while o_busy is low
//   o_busy                        CPU access pending or in progress
//   o_drop                        one-cycle pulse: a CPU strobe arrived while busy
module ppu_vram_arb (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_addr_wr,
    input  logic        i_data_wr,
    input  logic        i_data_rd,
    input  logic [7:0]  i_wdata,
    input  logic        i_latch_clr,
    input  logic        i_inc32,
    input  logic        i_rde_busy,
    input  logic [11:0] i_rde_nt_addr,
    input  logic [11:0] i_rde_pt_addr,
    input  logic [4:0]  i_rde_plt_addr,
    output logic [11:0] o_nt_addr,
    output logic        o_nt_we,
    output logic [7:0]  o_nt_wdata,
    input  logic [7:0]  i_nt_rdata,
    output logic [11:0] o_pt_addr,
    input  logic [15:0] i_pt_rdata,
    output logic [4:0]  o_plt_addr,
    output logic        o_plt_we,
    output logic [7:0]  o_plt_wdata,
    input  logic [7:0]  i_plt_rdata,
    output logic [7:0]  o_rdata,
    output logic        o_busy,
    output logic        o_drop
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] CAP  = 2'd2;

    logic [1:0]  state;
    logic [13:0] vaddr;      // current VRAM address
    logic        wtog;       // address write toggle: 0 = high byte next
    logic [13:0] acc_addr;   // address latched for the pending access
    logic [7:0]  acc_data;
    logic        acc_wr;
    logic [7:0]  rbuf;       // delayed read buffer

    logic        grant;
    logic        is_pat;
    logic        is_pal;
    logic        is_nt;
    logic        v_is_pal;
    logic        any_strobe;
    logic [4:0]  pal_idx;
    logic [7:0]  fetched;

    // Palette entries are 6 bits wide; the upper data bits are don't-care.
    logic        unused_plt_hi;
    assign unused_plt_hi = ^i_plt_rdata[7:6];

    assign o_busy     = (state != IDLE);
    assign grant      = (state == REQ) && !i_rde_busy;
    assign any_strobe = i_addr_wr || i_data_wr || i_data_rd;

    assign is_pat   = !acc_addr[13];
    assign is_pal   = (acc_addr[13:8] == 6'h3F);
    assign is_nt    = !is_pat && !is_pal;
    assign v_is_pal = (vaddr[13:8] == 6'h3F);

    // Sprite backdrop entries 0x10/14/18/1C alias the background ones.
    assign pal_idx = {acc_addr[4] && (acc_addr[1:0] != 2'b00), acc_addr[3:0]};

    assign fetched = is_pat ? (acc_addr[3] ? i_pt_rdata[15:8] : i_pt_rdata[7:0])
                            : i_nt_rdata;

    assign o_nt_wdata  = acc_data;
    assign o_plt_wdata = acc_data;

    always_comb begin
        o_nt_addr  = i_rde_nt_addr;
        o_pt_addr  = i_rde_pt_addr;
        o_plt_addr = i_rde_plt_addr;
        o_nt_we    = 1'b0;
        o_plt_we   = 1'b0;
        if (grant) begin
            // All three ports see the CPU address; a palette read therefore
            // also fetches the nametable byte underneath it for the buffer.
            o_nt_addr  = acc_addr[11:0];
            o_pt_addr  = {acc_addr[12:4], acc_addr[2:0]};
            o_plt_addr = pal_idx;
            o_nt_we    = acc_wr && is_nt;
            o_plt_we   = acc_wr && is_pal;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state    <= IDLE;
            vaddr    <= '0;
            wtog     <= 1'b0;
            acc_addr <= '0;
            acc_data <= '0;
            acc_wr   <= 1'b0;
            rbuf     <= '0;
            o_rdata  <= '0;
            o_drop   <= 1'b0;
        end else begin
            o_drop <= o_busy && any_strobe;
            if (i_latch_clr)
                wtog <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_addr_wr) begin
                        if (wtog)
                            vaddr[7:0] <= i_wdata;
                        else
                            vaddr[13:8] <= i_wdata[5:0];
                        // The write consumes the old toggle; a concurrent clear wins.
                        wtog <= !wtog && !i_latch_clr;
                    end
                    if (i_data_wr || i_data_rd) begin
                        acc_addr <= vaddr;
                        acc_data <= i_wdata;
                        acc_wr   <= i_data_wr;
                        state    <= REQ;
                        if (!i_data_wr && !v_is_pal)
                            o_rdata <= rbuf;
                    end
                end
                REQ: begin
                    if (!i_rde_busy) begin
                        vaddr <= vaddr + (i_inc32 ? 14'd32 : 14'd1);
                        state <= acc_wr ? IDLE : CAP;
                    end
                end
                CAP: begin
                    state <= IDLE;
                    if (is_pal) begin
                        o_rdata <= {2'b00, i_plt_rdata[5:0]};
                        rbuf    <= i_nt_rdata;
                    end else begin
                        rbuf <= fetched;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ppu_vram_arb.sv
// Bench for ppu_vram_arb: memories around the DUT, a transaction-level
// reference of the CPU-visible VRAM behaviour, directed steps then random ones.
module tb_ppu_vram_arb;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        addr_wr = 1'b0, data_wr = 1'b0, data_rd = 1'b0;
    logic [7:0]  wdata = '0;
    logic        latch_clr = 1'b0, inc32 = 1'b0, rde_busy = 1'b0;
    logic [11:0] rde_nt = '0, rde_pt = '0;
    logic [4:0]  rde_plt = '0;
    logic [11:0] nt_addr, pt_addr;
    logic [4:0]  plt_addr;
    logic        nt_we, plt_we, busy, drop;
    logic [7:0]  nt_wdata, plt_wdata, rdata;
    logic [7:0]  nt_q, plt_q;
    logic [15:0] pt_q;

    always #5 clk = ~clk;

    ppu_vram_arb dut (
        .i_clk(clk), .i_rstn(rstn), .i_addr_wr(addr_wr), .i_data_wr(data_wr),
        .i_data_rd(data_rd), .i_wdata(wdata), .i_latch_clr(latch_clr),
        .i_inc32(inc32), .i_rde_busy(rde_busy), .i_rde_nt_addr(rde_nt),
        .i_rde_pt_addr(rde_pt), .i_rde_plt_addr(rde_plt),
        .o_nt_addr(nt_addr), .o_nt_we(nt_we), .o_nt_wdata(nt_wdata), .i_nt_rdata(nt_q),
        .o_pt_addr(pt_addr), .i_pt_rdata(pt_q),
        .o_plt_addr(plt_addr), .o_plt_we(plt_we), .o_plt_wdata(plt_wdata), .i_plt_rdata(plt_q),
        .o_rdata(rdata), .o_busy(busy), .o_drop(drop)
    );

    // Memories attached to the DUT: one-cycle registered read.
    logic [7:0]  nt_mem [4096];
    logic [7:0]  pal_mem [32];
    logic [15:0] pt_rom [4096];

    always @(posedge clk) begin
        if (nt_we)  nt_mem[nt_addr]   <= nt_wdata;
        if (plt_we) pal_mem[plt_addr] <= plt_wdata;
        nt_q  <= nt_mem[nt_addr];
        plt_q <= pal_mem[plt_addr];
        pt_q  <= pt_rom[pt_addr];
    end

    // Reference: CPU view of the PPU address space.
    logic [7:0]  ref_nt [4096];
    logic [7:0]  ref_pal [32];
    logic [13:0] m_v = '0;
    logic        m_w = 1'b0;
    logic [7:0]  m_rbuf = '0;
    logic [7:0]  m_rdata = '0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] pal_index(input logic [13:0] a);
        logic [4:0] idx;
        idx = a[4:0];
        if (a[1:0] == 2'b00) idx[4] = 1'b0;
        return idx;
    endfunction

    function automatic logic [7:0] fetch_byte(input logic [13:0] a);
        logic [15:0] word;
        if (!a[13]) begin
            word = pt_rom[{a[12:4], a[2:0]}];
            return a[3] ? word[15:8] : word[7:0];
        end
        return ref_nt[a[11:0]];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_rde();
        rde_nt  = 12'($urandom);
        rde_pt  = 12'($urandom);
        rde_plt = 5'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            rde_busy = 1'($urandom);
            rand_rde();
            #1;
            chk("idle_nt_addr", nt_addr, rde_nt);
            chk("idle_we", {nt_we, plt_we}, 2'b00);
            tick();
        end
    endtask

    task automatic cpu_addr(input logic [7:0] d, input logic clr);
        addr_wr = 1'b1; wdata = d; latch_clr = clr;
        tick();
        addr_wr = 1'b0; latch_clr = 1'b0;
        if (m_w) m_v[7:0] = d;
        else     m_v[13:8] = d[5:0];
        m_w = !m_w && !clr;
        chk("addr_drop", drop, 1'b0);
    endtask

    task automatic clr_only();
        latch_clr = 1'b1;
        tick();
        latch_clr = 1'b0;
        m_w = 1'b0;
    endtask

    // One $2007 access; busy_n < 0 picks a random renderer hold-off.
    task automatic cpu_data(input logic is_wr, input logic [7:0] d, input int busy_n, input logic inj);
        logic [13:0] a;
        logic        pal, pat, nt;
        logic [4:0]  idx;
        int          nb;
        a   = m_v;
        pal = (a[13:8] == 6'h3F);
        pat = !a[13];
        nt  = !pal && !pat;
        idx = pal_index(a);
        nb  = (busy_n < 0) ? int'($urandom_range(0, 3)) : busy_n;

        data_wr = is_wr;
        data_rd = is_wr ? ($urandom_range(0, 3) == 0) : 1'b1;
        wdata = d;
        rde_busy = 1'($urandom);
        rand_rde();
        #1;
        chk("pre_busy", busy, 1'b0);
        tick();
        data_wr = 1'b0; data_rd = 1'b0;
        chk("strobe_busy", busy, 1'b1);
        chk("strobe_drop", drop, 1'b0);
        if (!is_wr && !pal) begin
            m_rdata = m_rbuf;
            chk("rdata_buf", rdata, m_rdata);
        end

        for (int i = 0; i <= nb; i++) begin
            rde_busy = (i < nb);
            rand_rde();
            wdata = 8'($urandom);
            addr_wr = inj && (i == 0);
            #1;
            if (i < nb) begin
                chk("wait_nt_addr", nt_addr, rde_nt);
                chk("wait_pt_addr", pt_addr, rde_pt);
                chk("wait_plt_addr", plt_addr, rde_plt);
                chk("wait_we", {nt_we, plt_we}, 2'b00);
                chk("wait_busy", busy, 1'b1);
            end else begin
                if (pat) chk("gr_pt_addr", pt_addr, {a[12:4], a[2:0]});
                if (!pat) chk("gr_nt_addr", nt_addr, a[11:0]);
                if (pal) chk("gr_plt_addr", plt_addr, idx);
                chk("gr_nt_we", nt_we, is_wr && nt);
                chk("gr_plt_we", plt_we, is_wr && pal);
                if (is_wr && nt)  chk("gr_nt_wdata", nt_wdata, d);
                if (is_wr && pal) chk("gr_plt_wdata", plt_wdata, d);
            end
            tick();
            addr_wr = 1'b0;
            if (i == 0) chk("drop_pulse", drop, inj);
        end
        m_v = m_v + (inc32 ? 14'd32 : 14'd1);

        if (is_wr) begin
            if (nt)  ref_nt[a[11:0]] = d;
            if (pal) ref_pal[idx] = d;
            chk("wr_done_busy", busy, 1'b0);
        end else begin
            chk("cap_busy", busy, 1'b1);
            rde_busy = 1'($urandom);
            rand_rde();
            tick();
            if (pal) begin
                m_rdata = {2'b00, ref_pal[idx][5:0]};
                m_rbuf  = ref_nt[a[11:0]];
            end else begin
                m_rbuf = fetch_byte(a);
            end
            chk("rd_done_busy", busy, 1'b0);
            chk("rd_rdata", rdata, m_rdata);
        end
    endtask

    initial begin
        int bad;
        logic [7:0] hi;
        int r;

        for (int i = 0; i < 4096; i++) begin
            ref_nt[i] = 8'($urandom);
            nt_mem[i] <= ref_nt[i];
            pt_rom[i] = 16'($urandom);
        end
        for (int i = 0; i < 32; i++) begin
            ref_pal[i] = 8'($urandom);
            pal_mem[i] <= ref_pal[i];
        end

        // Reset state
        tick(); tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_drop", drop, 1'b0);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_we", {nt_we, plt_we}, 2'b00);
        rstn = 1'b1;
        tick();

        // Nametable write at 0x2108, renderer idle
        cpu_addr(8'h21, 1'b0); cpu_addr(8'h08, 1'b0);
        cpu_data(1'b1, 8'h5A, 0, 1'b0);
        cpu_data(1'b0, 8'h00, 0, 1'b0);           // reads 0x2109
        cpu_data(1'b0, 8'h00, 0, 1'b0);

        // Step of 32 across the nametable boundary
        inc32 = 1'b1;
        cpu_addr(8'h23, 1'b0); cpu_addr(8'hE0, 1'b0);
        cpu_data(1'b0, 8'h00, 0, 1'b0);
        cpu_data(1'b0, 8'h00, 0, 1'b0);
        inc32 = 1'b0;

        // Palette mirror: write 0x3F10, read back through 0x3F00
        cpu_addr(8'h3F, 1'b0); cpu_addr(8'h10, 1'b0);
        cpu_data(1'b1, 8'h30, 0, 1'b0);
        cpu_addr(8'h3F, 1'b0); cpu_addr(8'h00, 1'b0);
        cpu_data(1'b0, 8'h00, 0, 1'b0);
        chk("pal_mirror_rd", rdata, 8'h30);

        // Renderer holds VRAM for 20 cycles
        cpu_addr(8'h20, 1'b0); cpu_addr(8'h00, 1'b0);
        cpu_data(1'b1, 8'hC3, 20, 1'b0);

        // Address write while busy is dropped
        cpu_data(1'b0, 8'h00, 2, 1'b1);
        cpu_data(1'b0, 8'h00, 0, 1'b0);

        // Toggle clear: alone, then together with an address write
        cpu_addr(8'h22, 1'b0); clr_only();
        cpu_addr(8'h24, 1'b0); cpu_addr(8'h56, 1'b0);
        cpu_data(1'b0, 8'h00, 1, 1'b0);
        cpu_addr(8'h25, 1'b0); cpu_addr(8'h77, 1'b1);
        cpu_addr(8'h26, 1'b1); cpu_addr(8'h0F, 1'b0);
        cpu_data(1'b1, 8'hE1, 0, 1'b0);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            inc32 = 1'($urandom);
            r = $urandom_range(0, 9);
            if (r <= 1) begin
                case ($urandom_range(0, 2))
                    0: hi = 8'($urandom_range(0, 8'h1F));
                    1: hi = 8'($urandom_range(8'h20, 8'h3E));
                    default: hi = 8'h3F;
                endcase
                hi[7:6] = 2'($urandom);
                cpu_addr(hi, $urandom_range(0, 7) == 0);
                cpu_addr(8'($urandom), 1'b0);
            end else if (r == 2) begin
                clr_only();
            end else if (r <= 5) begin
                cpu_data(1'b1, 8'($urandom), -1, $urandom_range(0, 9) == 0);
            end else begin
                cpu_data(1'b0, 8'h00, -1, $urandom_range(0, 9) == 0);
            end
            idle($urandom_range(0, 2));
        end

        // Address wrap at 0x3FFF, then reset in the middle of a read
        inc32 = 1'b0;
        clr_only();
        cpu_addr(8'h3F, 1'b0); cpu_addr(8'hFF, 1'b0);
        cpu_data(1'b0, 8'h00, 0, 1'b0);
        cpu_data(1'b0, 8'h00, 0, 1'b0);           // pattern address 0
        data_rd = 1'b1; rde_busy = 1'b0;
        tick();
        data_rd = 1'b0;
        tick();
        chk("cap_before_rst", busy, 1'b1);
        rstn = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_rdata", rdata, 8'h00);
        chk("arst_drop", drop, 1'b0);
        chk("arst_we", {nt_we, plt_we}, 2'b00);
        tick();
        rstn = 1'b1;
        m_v = '0; m_w = 1'b0; m_rbuf = '0; m_rdata = '0;
        tick();
        cpu_addr(8'h20, 1'b0); cpu_addr(8'h05, 1'b0);
        cpu_data(1'b0, 8'h00, 0, 1'b0);
        cpu_data(1'b0, 8'h00, 1, 1'b0);

        // Memory contents written through the DUT
        bad = 0;
        for (int i = 0; i < 4096; i++) if (nt_mem[i] !== ref_nt[i]) bad++;
        chk("nt_mem_diffs", bad, 0);
        bad = 0;
        for (int i = 0; i < 32; i++) if (pal_mem[i] !== ref_pal[i]) bad++;
        chk("pal_mem_diffs", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
